// File: rtl/dsp_add_v4_packer_pkg.sv
// Shared SIMD lane definitions for the four-lane 12-bit DSP adder family.
package dsp_simd_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 12;

  typedef logic [LANES-1:0] lane_mask_t;
  typedef logic [1:0]       lane_idx_t;

  // Bit offsets of each lane inside a flat 48-bit operand word.
  localparam int unsigned LANE_OFS [LANES] = '{0, 12, 24, 36};

  function automatic lane_mask_t lane_onehot(input lane_idx_t idx);
    lane_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/dsp_add_v4_packer_if.sv
// Scalar-in / vector-out handshake bundle for the SIMD adder feeder.
interface dsp_add_v4_packer_if #(parameter int width = 12);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_a;
  logic [width-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] a0, a1, a2, a3;
  logic [width-1:0] b0, b1, b2, b3;
  logic [3:0]       out_mask;
  logic             out_last;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, a0, a1, a2, a3, b0, b1, b2, b3, out_mask, out_last
  );
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, a0, a1, a2, a3, b0, b1, b2, b3, out_mask, out_last
  );
endinterface

// File: rtl/dsp_add_v4_packer_bank.sv
// Four-lane a/b register bank with per-lane write enable, lane mask and clear.
module simd_lane_bank
  import dsp_simd_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  lane_mask_t              we,
  input  lane_mask_t              d_mask,
  input  logic [LANES-1:0][W-1:0] d_a,
  input  logic [LANES-1:0][W-1:0] d_b,
  output logic [LANES-1:0][W-1:0] q_a,
  output logic [LANES-1:0][W-1:0] q_b,
  output lane_mask_t              q_mask
);
  // A lane write wins over clear so a lane can be refilled while the rest empty.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset) begin
        q_a[i]    <= '0;
        q_b[i]    <= '0;
        q_mask[i] <= 1'b0;
      end else if (we[i]) begin
        q_a[i]    <= d_a[i];
        q_b[i]    <= d_b[i];
        q_mask[i] <= d_mask[i];
      end else if (clr) begin
        q_a[i]    <= '0;
        q_b[i]    <= '0;
        q_mask[i] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dsp_add_v4_packer.sv
// Packs a scalar (a,b) operand stream into 4-lane vectors with a lane-valid mask.
module dsp_add_v4_packer
  import dsp_simd_pkg::*;
#(
  parameter int width = LANE_W
) (
  input logic                 clock,
  input logic                 reset,
  dsp_add_v4_packer_if.slave  bus
);
  if (width < 1 || width > LANE_W) begin : g_bad_width
    $error("dsp_add_v4_packer: width must be in 1..12");
  end

  typedef logic [LANES-1:0][width-1:0] vec_t;

  lane_idx_t  cnt;
  logic       asm_full, asm_last, out_valid, out_last;
  logic       acc, complete, free, load_direct, transfer, out_load;
  lane_mask_t sel, vec_m, asm_m, o_m;
  vec_t       rep_a, rep_b, vec_a, vec_b, asm_a, asm_b, o_a, o_b;

  assign bus.in_ready = !asm_full && !reset;
  assign acc          = bus.in_valid && bus.in_ready;
  assign complete     = acc && (cnt == 2'd3 || bus.in_last);
  assign free         = !out_valid || bus.out_ready;
  assign load_direct  = complete && free;
  assign transfer     = asm_full && free;
  assign out_load     = load_direct || transfer;
  assign sel          = acc ? lane_onehot(cnt) : '0;
  assign vec_m        = asm_m | sel;

  // The vector seen by the output bank: held lanes plus the lane being accepted.
  always_comb begin
    rep_a = '0;
    rep_b = '0;
    vec_a = '0;
    vec_b = '0;
    for (int i = 0; i < LANES; i++) begin
      rep_a[i] = bus.in_a;
      rep_b[i] = bus.in_b;
      if (vec_m[i]) begin
        vec_a[i] = sel[i] ? bus.in_a : asm_a[i];
        vec_b[i] = sel[i] ? bus.in_b : asm_b[i];
      end
    end
  end

  simd_lane_bank #(.W(width)) u_asm (
    .clock (clock), .reset (reset), .clr (out_load),
    .we    (sel & {LANES{!load_direct}}), .d_mask ('1),
    .d_a   (rep_a), .d_b (rep_b),
    .q_a   (asm_a), .q_b (asm_b), .q_mask (asm_m)
  );

  simd_lane_bank #(.W(width)) u_out (
    .clock (clock), .reset (reset), .clr (1'b0),
    .we    ({LANES{out_load}}), .d_mask (vec_m),
    .d_a   (vec_a), .d_b (vec_b),
    .q_a   (o_a), .q_b (o_b), .q_mask (o_m)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      asm_full  <= 1'b0;
      asm_last  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (acc) cnt <= complete ? 2'd0 : cnt + 2'd1;
      if (complete && !free) begin
        asm_full <= 1'b1;
        asm_last <= bus.in_last;
      end else if (transfer) begin
        asm_full <= 1'b0;
        asm_last <= 1'b0;
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_last  <= transfer ? asm_last : bus.in_last;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_mask  = o_m;
  assign bus.a0 = o_a[0];
  assign bus.a1 = o_a[1];
  assign bus.a2 = o_a[2];
  assign bus.a3 = o_a[3];
  assign bus.b0 = o_b[0];
  assign bus.b1 = o_b[1];
  assign bus.b2 = o_b[2];
  assign bus.b3 = o_b[3];
endmodule

// File: tb/tb_dsp_add_v4_packer.sv
// Directed-vector bench for dsp_add_v4_packer (12-bit and 8-bit instances).
module tb_dsp_add_v4_packer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  dsp_add_v4_packer_if #(.width(12)) bus ();
  dsp_add_v4_packer_if #(.width(8))  bus8 ();

  dsp_add_v4_packer #(.width(12)) dut  (.clock(clock), .reset(reset), .bus(bus.slave));
  dsp_add_v4_packer #(.width(8))  dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int a, input int b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = 12'(a);
    bus.in_b     = 12'(b);
    bus.in_last  = last;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_mask !== 4'b0) begin errors++; $display("FAIL rst_out_mask: got %b want 0000", bus.out_mask); end
    checks++; if (bus.a0 !== 12'd0 || bus.b3 !== 12'd0) begin errors++; $display("FAIL rst_data: got a0=%0d b3=%0d want 0", bus.a0, bus.b3); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_hi: got %b want 0", bus.in_ready); end
    reset = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_full_vector();
    int drops = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2*i + 1, 2*i + 2, 1'b0);
      if (bus.in_ready !== 1'b1) drops++;
      step();
      if (i == 2) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b want 0", bus.out_valid); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
    checks++; if ({bus.a0, bus.a1, bus.a2, bus.a3} !== {12'd1, 12'd3, 12'd5, 12'd7}) begin errors++; $display("FAIL full_a: got %0d %0d %0d %0d want 1 3 5 7", bus.a0, bus.a1, bus.a2, bus.a3); end
    checks++; if ({bus.b0, bus.b1, bus.b2, bus.b3} !== {12'd2, 12'd4, 12'd6, 12'd8}) begin errors++; $display("FAIL full_b: got %0d %0d %0d %0d want 2 4 6 8", bus.b0, bus.b1, bus.b2, bus.b3); end
    checks++; if (bus.out_mask !== 4'b1111 || bus.out_last !== 1'b0) begin errors++; $display("FAIL full_mask_last: got %b/%b want 1111/0", bus.out_mask, bus.out_last); end
    checks++; if (drops != 0) begin errors++; $display("FAIL full_in_ready: got %0d drops want 0", drops); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_partial_last();
    bus.out_ready = 1'b1;
    drive(9, 1, 1'b0);  step();
    drive(10, 2, 1'b1); step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_mask !== 4'b0011) begin errors++; $display("FAIL part_mask: got v=%b m=%b want 1/0011", bus.out_valid, bus.out_mask); end
    checks++; if ({bus.a0, bus.a1, bus.b0, bus.b1} !== {12'd9, 12'd10, 12'd1, 12'd2}) begin errors++; $display("FAIL part_data: got %0d %0d %0d %0d want 9 10 1 2", bus.a0, bus.a1, bus.b0, bus.b1); end
    checks++; if ({bus.a2, bus.a3, bus.b2, bus.b3} !== 48'd0) begin errors++; $display("FAIL part_zero: got %0d %0d %0d %0d want 0", bus.a2, bus.a3, bus.b2, bus.b3); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL part_last: got %b want 1", bus.out_last); end
    drive(11, 12, 1'b0); step();
    drive(13, 14, 1'b1); step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_mask !== 4'b0011 || bus.a0 !== 12'd11 || bus.a1 !== 12'd13) begin errors++; $display("FAIL part_next_lane0: got m=%b a0=%0d a1=%0d want 0011 11 13", bus.out_mask, bus.a0, bus.a1); end
    step();
  endtask

  task automatic test_backpressure();
    int drops = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(20 + i, 40 + i, 1'b0);
      if (bus.in_ready !== 1'b1) drops++;
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (drops != 0) begin errors++; $display("FAIL bp_accept: got %0d drops want 0", drops); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", bus.in_ready); end
    step(); step(); step();
    checks++; if (bus.out_valid !== 1'b1 || bus.a0 !== 12'd20 || bus.a3 !== 12'd23 || bus.b1 !== 12'd41) begin errors++; $display("FAIL bp_hold1: got v=%b a0=%0d a3=%0d b1=%0d want 1 20 23 41", bus.out_valid, bus.a0, bus.a3, bus.b1); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.a0 !== 12'd24 || bus.a3 !== 12'd27 || bus.b0 !== 12'd44 || bus.out_mask !== 4'b1111) begin errors++; $display("FAIL bp_vec2: got v=%b a0=%0d a3=%0d b0=%0d m=%b want 1 24 27 44 1111", bus.out_valid, bus.a0, bus.a3, bus.b0, bus.out_mask); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b want 1", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.a1 !== 12'd25) begin errors++; $display("FAIL bp_hold2: got v=%b a1=%0d want 1 25", bus.out_valid, bus.a1); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int drops = 0, nvec = 0, terr = 0, derr = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(i, i + 100, 1'b0);
      if (bus.in_ready !== 1'b1) drops++;
      step();
      if (bus.out_valid !== ((i % 4) == 3)) terr++;
      if (bus.out_valid === 1'b1) begin
        if (bus.a0 !== 12'(4*nvec) || bus.a3 !== 12'(4*nvec + 3) ||
            bus.b1 !== 12'(4*nvec + 101) || bus.out_mask !== 4'b1111) derr++;
        nvec++;
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (nvec != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", nvec); end
    checks++; if (terr != 0) begin errors++; $display("FAIL b2b_timing: got %0d errs want 0", terr); end
    checks++; if (derr != 0) begin errors++; $display("FAIL b2b_data: got %0d errs want 0", derr); end
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_in_ready: got %0d drops want 0", drops); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(60 + i, 70 + i, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_mask !== 4'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got v=%b m=%b l=%b want 0", bus.out_valid, bus.out_mask, bus.out_last); end
    checks++; if ({bus.a0, bus.a3, bus.b0, bus.b3} !== 48'd0) begin errors++; $display("FAIL rmid_data: got %0d %0d %0d %0d want 0", bus.a0, bus.a3, bus.b0, bus.b3); end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(50 + i, 80 + i, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.a0 !== 12'd50 || bus.a3 !== 12'd53 || bus.b0 !== 12'd80 || bus.out_mask !== 4'b1111) begin errors++; $display("FAIL rmid_fresh: got v=%b a0=%0d a3=%0d b0=%0d m=%b want 1 50 53 80 1111", bus.out_valid, bus.a0, bus.a3, bus.b0, bus.out_mask); end
    step();
  endtask

  task automatic test_width8();
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.in_a      = 8'hFF;
    bus8.in_b      = 8'h01;
    bus8.in_last   = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    checks++; if (bus8.out_valid !== 1'b1 || bus8.out_mask !== 4'b0001) begin errors++; $display("FAIL w8_ctrl: got v=%b m=%b want 1 0001", bus8.out_valid, bus8.out_mask); end
    checks++; if (bus8.a0 !== 8'hFF || bus8.b0 !== 8'h01) begin errors++; $display("FAIL w8_data: got a0=%h b0=%h want ff 01", bus8.a0, bus8.b0); end
    checks++; if ({bus8.a1, bus8.a2, bus8.a3, bus8.b1, bus8.b2, bus8.b3} !== 48'd0) begin errors++; $display("FAIL w8_upper: got a1=%h a3=%h b3=%h want 0", bus8.a1, bus8.a3, bus8.b3); end
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_last = 1'b0;  bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_last = 1'b0; bus8.out_ready = 1'b0;
    test_reset();
    test_full_vector();
    test_partial_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
